// File: rtl/multicycle_main_controller.sv
// ============================================================================
// Module      : multicycle_main_controller
// Description : Multi-cycle RV32I main control FSM. Sequences fetch, decode,
//               execute, memory and write-back steps with memory wait-states
//               and illegal-opcode trapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_main_controller #(
    parameter logic SUPPORT_U       = 1'b1,
    parameter logic SUPPORT_JALR    = 1'b1,
    parameter logic MEM_HANDSHAKE   = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       adr_sel,
    output logic       mem_read,
    output logic       memwrite_en,
    output logic       regwrite_en,
    output logic [2:0] imm_sel,
    output logic       b_imm_sel,
    output logic       a_pc_sel,
    output logic [1:0] alu_type_sel,
    output logic [1:0] wb_sel,
    output logic       branch,
    output logic       jump,
    output logic       illegal_instr,
    output logic [3:0] state
);

    localparam logic [3:0] c_st_fetch    = 4'd0;
    localparam logic [3:0] c_st_decode   = 4'd1;
    localparam logic [3:0] c_st_memadr   = 4'd2;
    localparam logic [3:0] c_st_memread  = 4'd3;
    localparam logic [3:0] c_st_memwb    = 4'd4;
    localparam logic [3:0] c_st_memwrite = 4'd5;
    localparam logic [3:0] c_st_exec_r   = 4'd6;
    localparam logic [3:0] c_st_exec_i   = 4'd7;
    localparam logic [3:0] c_st_aluwb    = 4'd8;
    localparam logic [3:0] c_st_branch   = 4'd9;
    localparam logic [3:0] c_st_jal      = 4'd10;
    localparam logic [3:0] c_st_jalr     = 4'd11;
    localparam logic [3:0] c_st_upper    = 4'd12;
    localparam logic [3:0] c_st_trap     = 4'd13;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_dispatch;
    logic       w_ready;

    assign w_ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_next;
        end
    end

    // Illegal or parameter-disabled opcodes resolve to TRAP or a silent NOP.
    always_comb begin
        w_dispatch = TRAP_ON_ILLEGAL ? c_st_trap : c_st_fetch;
        case (opcode)
            c_op_load, c_op_store: w_dispatch = c_st_memadr;
            c_op_r:                w_dispatch = c_st_exec_r;
            c_op_i:                w_dispatch = c_st_exec_i;
            c_op_branch:           w_dispatch = c_st_branch;
            c_op_jal:              w_dispatch = c_st_jal;
            c_op_jalr:             if (SUPPORT_JALR) w_dispatch = c_st_jalr;
            c_op_lui, c_op_auipc:  if (SUPPORT_U) w_dispatch = c_st_upper;
            default:               ;
        endcase
    end

    always_comb begin
        w_next = c_st_fetch;
        case (r_state)
            c_st_fetch:    w_next = w_ready ? c_st_decode : c_st_fetch;
            c_st_decode:   w_next = w_dispatch;
            c_st_memadr:   w_next = (opcode == c_op_store) ? c_st_memwrite : c_st_memread;
            c_st_memread:  w_next = w_ready ? c_st_memwb : c_st_memread;
            c_st_memwb:    w_next = c_st_fetch;
            c_st_memwrite: w_next = w_ready ? c_st_fetch : c_st_memwrite;
            c_st_exec_r:   w_next = c_st_aluwb;
            c_st_exec_i:   w_next = c_st_aluwb;
            c_st_trap:     w_next = c_st_trap;
            default:       w_next = c_st_fetch;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        adr_sel       = 1'b0;
        mem_read      = 1'b0;
        memwrite_en   = 1'b0;
        regwrite_en   = 1'b0;
        imm_sel       = 3'b000;
        b_imm_sel     = 1'b0;
        a_pc_sel      = 1'b0;
        alu_type_sel  = 2'b00;
        wb_sel        = 2'b00;
        branch        = 1'b0;
        jump          = 1'b0;
        illegal_instr = 1'b0;
        state         = r_state;
        case (r_state)
            c_st_fetch: begin
                mem_read = 1'b1;
                pc_write = w_ready;
                ir_write = w_ready;
            end
            c_st_memadr: begin
                imm_sel   = (opcode == c_op_store) ? 3'b001 : 3'b000;
                b_imm_sel = 1'b1;
            end
            c_st_memread: begin
                adr_sel  = 1'b1;
                mem_read = 1'b1;
            end
            c_st_memwb: begin
                regwrite_en = 1'b1;
                wb_sel      = 2'b01;
            end
            c_st_memwrite: begin
                adr_sel     = 1'b1;
                memwrite_en = 1'b1;
            end
            c_st_exec_r: alu_type_sel = 2'b01;
            c_st_exec_i: begin
                alu_type_sel = 2'b11;
                b_imm_sel    = 1'b1;
            end
            c_st_aluwb: regwrite_en = 1'b1;
            c_st_branch: begin
                branch       = 1'b1;
                imm_sel      = 3'b010;
                alu_type_sel = 2'b10;
            end
            c_st_jal: begin
                jump        = 1'b1;
                pc_write    = 1'b1;
                imm_sel     = 3'b011;
                regwrite_en = 1'b1;
                wb_sel      = 2'b10;
            end
            c_st_jalr: begin
                jump        = 1'b1;
                pc_write    = 1'b1;
                b_imm_sel   = 1'b1;
                regwrite_en = 1'b1;
                wb_sel      = 2'b10;
            end
            c_st_upper: begin
                imm_sel     = 3'b100;
                regwrite_en = 1'b1;
                if (opcode == c_op_lui) begin
                    wb_sel = 2'b11;
                end else begin
                    a_pc_sel  = 1'b1;
                    b_imm_sel = 1'b1;
                end
            end
            c_st_trap: illegal_instr = 1'b1;
            default: ;
        endcase
        // Reset masks everything so an aborted instruction never issues a write.
        if (rst) begin
            pc_write      = 1'b0;
            ir_write      = 1'b0;
            adr_sel       = 1'b0;
            mem_read      = 1'b0;
            memwrite_en   = 1'b0;
            regwrite_en   = 1'b0;
            imm_sel       = 3'b000;
            b_imm_sel     = 1'b0;
            a_pc_sel      = 1'b0;
            alu_type_sel  = 2'b00;
            wb_sel        = 2'b00;
            branch        = 1'b0;
            jump          = 1'b0;
            illegal_instr = 1'b0;
            state         = 4'd0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_controller.sv
// ============================================================================
// Module      : tb_multicycle_main_controller
// Description : Scoreboard bench for multicycle_main_controller across four
//               parameter sets with directed per-cycle expected outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_main_controller;

    // dut0 default, dut1 no handshake, dut2 illegal-as-NOP, dut3 no U/JALR
    localparam logic [3:0] c_su = 4'b0111;
    localparam logic [3:0] c_sj = 4'b0111;
    localparam logic [3:0] c_mh = 4'b1101;
    localparam logic [3:0] c_tr = 4'b1011;

    localparam logic [6:0] c_ld  = 7'b0000011;
    localparam logic [6:0] c_st  = 7'b0100011;
    localparam logic [6:0] c_r   = 7'b0110011;
    localparam logic [6:0] c_i   = 7'b0010011;
    localparam logic [6:0] c_b   = 7'b1100011;
    localparam logic [6:0] c_jal = 7'b1101111;
    localparam logic [6:0] c_jr  = 7'b1100111;
    localparam logic [6:0] c_lui = 7'b0110111;
    localparam logic [6:0] c_aui = 7'b0010111;
    localparam logic [6:0] c_bad = 7'b1111111;

    typedef struct {
        int          dut;
        logic [21:0] exp;
        string       tag;
    } sb_t;

    logic             clk = 1'b0;
    logic [3:0]       rst_v = 4'b1111;
    logic [3:0]       rdy_v = 4'b0000;
    logic [6:0]       opc [4];
    logic [3:0][21:0] act;
    sb_t              sb_q[$];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        logic       pc_write, ir_write, adr_sel, mem_read, memwrite_en, regwrite_en;
        logic       b_imm_sel, a_pc_sel, branch, jump, illegal_instr;
        logic [2:0] imm_sel;
        logic [1:0] alu_type_sel, wb_sel;
        logic [3:0] state;

        multicycle_main_controller #(
            .SUPPORT_U      (c_su[i]),
            .SUPPORT_JALR   (c_sj[i]),
            .MEM_HANDSHAKE  (c_mh[i]),
            .TRAP_ON_ILLEGAL(c_tr[i])
        ) u_dut (
            .clk          (clk),
            .rst          (rst_v[i]),
            .opcode       (opc[i]),
            .mem_ready    (rdy_v[i]),
            .pc_write     (pc_write),
            .ir_write     (ir_write),
            .adr_sel      (adr_sel),
            .mem_read     (mem_read),
            .memwrite_en  (memwrite_en),
            .regwrite_en  (regwrite_en),
            .imm_sel      (imm_sel),
            .b_imm_sel    (b_imm_sel),
            .a_pc_sel     (a_pc_sel),
            .alu_type_sel (alu_type_sel),
            .wb_sel       (wb_sel),
            .branch       (branch),
            .jump         (jump),
            .illegal_instr(illegal_instr),
            .state        (state)
        );

        assign act[i] = {state, pc_write, ir_write, adr_sel, mem_read, memwrite_en,
                         regwrite_en, imm_sel, b_imm_sel, a_pc_sel, alu_type_sel,
                         wb_sel, branch, jump, illegal_instr};
    end

    function automatic logic [21:0] v(logic [3:0] st, logic pcw, logic irw, logic adr,
                                      logic mr, logic mw, logic rw, logic [2:0] imm,
                                      logic bimm, logic apc, logic [1:0] alut,
                                      logic [1:0] wb, logic br, logic jmp, logic ill);
        return {st, pcw, irw, adr, mr, mw, rw, imm, bimm, apc, alut, wb, br, jmp, ill};
    endfunction

    function automatic logic [21:0] f_go();
        return v(4'd0, 1, 1, 0, 1, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_wait();
        return v(4'd0, 0, 0, 0, 1, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_dec();
        return v(4'd1, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction

    function automatic logic [21:0] f_trap();
        return v(4'd13, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    endfunction

    // Drive one cycle on one DUT (others held in reset) and queue its expected outputs.
    task automatic cyc(input int d, input logic r, input logic [6:0] op, input logic rdy,
                       input logic [21:0] e, input string tag);
        rst_v    = 4'b1111;
        rst_v[d] = r;
        rdy_v    = 4'b0000;
        rdy_v[d] = rdy;
        opc[d]   = op;
        sb_q.push_back('{dut: d, exp: e, tag: tag});
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            sb_t s;
            s = sb_q.pop_front();
            checks++;
            if (act[s.dut] !== s.exp) begin
                errors++;
                $display("FAIL %s dut%0d: got %h expected %h", s.tag, s.dut, act[s.dut], s.exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 4; k++) opc[k] = 7'd0;
        @(posedge clk);
        #1;
        // dut0: reset, then R-type 0,1,6,8
        cyc(0, 1, c_r, 1, 22'd0, "rst_a");
        cyc(0, 1, c_r, 1, 22'd0, "rst_b");
        cyc(0, 0, c_r, 1, f_go(), "r_fetch");
        cyc(0, 0, c_r, 1, f_dec(), "r_decode");
        cyc(0, 0, c_r, 1, v(6, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b01, 2'b00, 0, 0, 0), "r_exec");
        cyc(0, 0, c_r, 1, v(8, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "r_aluwb");
        // load with 3 wait states in MEMREAD
        cyc(0, 0, c_ld, 1, f_go(), "ld_fetch");
        cyc(0, 0, c_ld, 1, f_dec(), "ld_decode");
        cyc(0, 0, c_ld, 1, v(2, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 2'b00, 2'b00, 0, 0, 0), "ld_memadr");
        for (int k = 0; k < 3; k++)
            cyc(0, 0, c_ld, 0, v(3, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "ld_memread_wait");
        cyc(0, 0, c_ld, 1, v(3, 0, 0, 1, 1, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "ld_memread_done");
        cyc(0, 0, c_ld, 1, v(4, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2'b00, 2'b01, 0, 0, 0), "ld_memwb");
        // store with a fetch wait and a write wait
        cyc(0, 0, c_st, 0, f_wait(), "st_fetch_wait");
        cyc(0, 0, c_st, 1, f_go(), "st_fetch");
        cyc(0, 0, c_st, 1, f_dec(), "st_decode");
        cyc(0, 0, c_st, 0, v(2, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 2'b00, 2'b00, 0, 0, 0), "st_memadr");
        cyc(0, 0, c_st, 0, v(5, 0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "st_memwrite_wait");
        cyc(0, 0, c_st, 1, v(5, 0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "st_memwrite_done");
        // I-type
        cyc(0, 0, c_i, 1, f_go(), "i_fetch");
        cyc(0, 0, c_i, 1, f_dec(), "i_decode");
        cyc(0, 0, c_i, 1, v(7, 0, 0, 0, 0, 0, 0, 3'b000, 1, 0, 2'b11, 2'b00, 0, 0, 0), "i_exec");
        cyc(0, 0, c_i, 1, v(8, 0, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "i_aluwb");
        // branch, JAL, JALR, LUI, AUIPC
        cyc(0, 0, c_b, 1, f_go(), "b_fetch");
        cyc(0, 0, c_b, 1, f_dec(), "b_decode");
        cyc(0, 0, c_b, 1, v(9, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 2'b10, 2'b00, 1, 0, 0), "b_branch");
        cyc(0, 0, c_jal, 1, f_go(), "jal_fetch");
        cyc(0, 0, c_jal, 1, f_dec(), "jal_decode");
        cyc(0, 0, c_jal, 1, v(10, 1, 0, 0, 0, 0, 1, 3'b011, 0, 0, 2'b00, 2'b10, 0, 1, 0), "jal_exec");
        cyc(0, 0, c_jr, 1, f_go(), "jalr_fetch");
        cyc(0, 0, c_jr, 1, f_dec(), "jalr_decode");
        cyc(0, 0, c_jr, 1, v(11, 1, 0, 0, 0, 0, 1, 3'b000, 1, 0, 2'b00, 2'b10, 0, 1, 0), "jalr_exec");
        cyc(0, 0, c_lui, 1, f_go(), "lui_fetch");
        cyc(0, 0, c_lui, 1, f_dec(), "lui_decode");
        cyc(0, 0, c_lui, 1, v(12, 0, 0, 0, 0, 0, 1, 3'b100, 0, 0, 2'b00, 2'b11, 0, 0, 0), "lui_upper");
        cyc(0, 0, c_aui, 1, f_go(), "auipc_fetch");
        cyc(0, 0, c_aui, 1, f_dec(), "auipc_decode");
        cyc(0, 0, c_aui, 1, v(12, 0, 0, 0, 0, 0, 1, 3'b100, 1, 1, 2'b00, 2'b00, 0, 0, 0), "auipc_upper");
        // rst during MEMWRITE aborts the write
        cyc(0, 0, c_st, 1, f_go(), "abort_fetch");
        cyc(0, 0, c_st, 1, f_dec(), "abort_decode");
        cyc(0, 0, c_st, 0, v(2, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 2'b00, 2'b00, 0, 0, 0), "abort_memadr");
        cyc(0, 0, c_st, 0, v(5, 0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "abort_memwrite");
        cyc(0, 1, c_st, 1, 22'd0, "abort_rst");
        cyc(0, 0, c_st, 0, f_wait(), "abort_after_rst");
        // illegal opcode traps until reset
        cyc(0, 0, c_bad, 1, f_go(), "bad_fetch");
        cyc(0, 0, c_bad, 1, f_dec(), "bad_decode");
        for (int k = 0; k < 3; k++) cyc(0, 0, c_bad, 1, f_trap(), "bad_trap_sticky");
        cyc(0, 1, c_bad, 1, 22'd0, "bad_rst");
        cyc(0, 0, c_r, 0, f_wait(), "bad_after_rst");

        // dut1: no handshake, store completes with mem_ready low
        cyc(1, 1, c_st, 0, 22'd0, "nh_rst");
        cyc(1, 0, c_st, 0, f_go(), "nh_fetch");
        cyc(1, 0, c_st, 0, f_dec(), "nh_decode");
        cyc(1, 0, c_st, 0, v(2, 0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 2'b00, 2'b00, 0, 0, 0), "nh_memadr");
        cyc(1, 0, c_st, 0, v(5, 0, 0, 1, 0, 1, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0), "nh_memwrite");
        cyc(1, 0, c_st, 0, f_go(), "nh_back_to_fetch");

        // dut2: illegal treated as NOP
        cyc(2, 1, c_bad, 1, 22'd0, "nop_rst");
        cyc(2, 0, c_bad, 1, f_go(), "nop_fetch");
        cyc(2, 0, c_bad, 1, f_dec(), "nop_decode");
        cyc(2, 0, c_bad, 0, f_wait(), "nop_back_to_fetch");

        // dut3: LUI and JALR disabled -> trap
        cyc(3, 1, c_lui, 1, 22'd0, "nou_rst");
        cyc(3, 0, c_lui, 1, f_go(), "nou_fetch");
        cyc(3, 0, c_lui, 1, f_dec(), "nou_decode");
        cyc(3, 0, c_lui, 1, f_trap(), "nou_trap");
        cyc(3, 1, c_jr, 1, 22'd0, "noj_rst");
        cyc(3, 0, c_jr, 1, f_go(), "noj_fetch");
        cyc(3, 0, c_jr, 1, f_dec(), "noj_decode");
        cyc(3, 0, c_jr, 1, f_trap(), "noj_trap");

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
